logic_unit_arbiter: RTL

//  Shares one WIDTH-bit registered logic-gate unit (AND/OR/XOR/NAND) between
//  N_REQ requesters. Round-robin arbitration, valid/ready request per

---
 rtl/logic_unit_arbiter_pkg.sv | 17 +
 rtl/logic_unit_arbiter_rr_arbiter.sv | 28 ++
 rtl/logic_unit_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: opcodes and FSM states shared by gate-unit controllers
package logic_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request above ptr wins
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  // scan from farthest to nearest so the nearest requester above ptr wins
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sequencer sharing one registered gate unit
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data
);

  state_e           state, state_nxt;
  logic [ID_W-1:0]  ptr, id_q, grant_id;
  logic [N_REQ-1:0] grant;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic             start;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign start     = state == ST_IDLE && |req_valid;
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
  assign rsp_valid = state == ST_RESP;

  // next state: one grant per pass through IDLE -> EXEC -> RESP
  always_comb begin
    state_nxt = state;
    state_nxt = start ? ST_EXEC :
                state == ST_EXEC ? ST_RESP :
                (state == ST_RESP && rsp_ready) ? ST_IDLE : state;
  end

  // gate function over the latched operands
  always_comb begin
    result = '0;
    result = op_q == OP_AND ? a_q & b_q :
             op_q == OP_OR  ? a_q | b_q :
             op_q == OP_XOR ? a_q ^ b_q : ~(a_q & b_q);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // operand capture on grant, result on EXEC, ptr moves on response accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= ID_W'(N_REQ - 1);
      id_q     <= '0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      if (start) begin
        id_q <= grant_id;
        op_q <= op_e'(req_op[2*grant_id +: 2]);
        a_q  <= req_a[WIDTH*grant_id +: WIDTH];
        b_q  <= req_b[WIDTH*grant_id +: WIDTH];
      end
      if (state == ST_EXEC) begin
        rsp_data <= result;
        rsp_id   <= id_q;
      end
      if (rsp_valid && rsp_ready) ptr <= id_q;
    end
  end

endmodule
